// File: rtl/cls_pkg.sv
// Shared types for counter_load_sched: FSM state encoding and watchdog limit.
// The watchdog itself is compiled only when CLS_WATCHDOG_EN is defined.
package cls_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } cls_state_e;

  // A healthy job runs at most 2^width cycles; one more is tolerated before giving up.
  function automatic int unsigned cls_wd_limit(input int unsigned width);
    return (32'd1 << width) + 32'd1;
  endfunction

endpackage

// File: rtl/cls_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after the pointer.
module cls_rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_onehot,
  output logic [IW-1:0]   o_idx,
  output logic            o_valid
);

  logic [IW-1:0] w_cand [NREQ];

  for (genvar k = 0; k < NREQ; k++) begin : g_cand
    assign w_cand[k] = IW'((int'(i_ptr) + k) % NREQ);
  end

  // Scan candidates in priority order starting at the pointer.
  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_valid  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!o_valid && i_req[w_cand[k]]) begin
        o_valid            = 1'b1;
        o_idx              = w_cand[k];
        o_onehot[w_cand[k]] = 1'b1;
      end else begin
        o_valid = o_valid;
      end
    end
  end

endmodule

// File: rtl/counter_load_sched.sv
// Round-robin scheduler sharing one loadable up-counter between NREQ requesters.
// Optional RUN watchdog and timeout port enabled by defining CLS_WATCHDOG_EN.
module counter_load_sched
  import cls_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int NREQ  = 2
) (
  input  logic                  clk,
  input  logic                  Rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] start_val,
  input  logic [NREQ*WIDTH-1:0] stop_val,
  input  logic                  abort,
  input  logic [WIDTH-1:0]      cnt_in,
  output logic                  ld_en,
  output logic [WIDTH-1:0]      load,
  output logic                  cnt_en,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  aborted,
  output logic                  busy
`ifdef CLS_WATCHDOG_EN
  ,
  output logic                  timeout
`endif
);

  localparam int IW = $clog2(NREQ);

  cls_state_e      r_state, w_state_nxt;
  logic [IW-1:0]   r_idx, r_ptr, w_arb_idx, w_ptr_nxt;
  logic [NREQ-1:0] r_gnt, w_arb_onehot;
  logic            w_arb_valid;
  logic [WIDTH-1:0] r_start, r_stop;
  logic            r_aborted, w_abort_exit, w_job_exit, w_wd_expired;

  cls_rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .i_req    (req),
    .i_ptr    (r_ptr),
    .o_onehot (w_arb_onehot),
    .o_idx    (w_arb_idx),
    .o_valid  (w_arb_valid)
  );

  // Next-state decode; abort and watchdog expiry both leave RUN through the abort path.
  always_comb begin
    w_state_nxt  = r_state;
    w_abort_exit = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_arb_valid) w_state_nxt = LOAD;
        else             w_state_nxt = IDLE;
      end
      LOAD: begin
        if (abort) begin
          w_state_nxt  = IDLE;
          w_abort_exit = 1'b1;
        end else begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (abort || w_wd_expired) begin
          w_state_nxt  = IDLE;
          w_abort_exit = 1'b1;
        end else if (cnt_in == r_stop) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = RUN;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_job_exit = w_abort_exit || (r_state == DONE);
  assign w_ptr_nxt  = (r_idx == IW'(NREQ - 1)) ? '0 : r_idx + IW'(1);

  // State, job latches, grant and round-robin pointer.
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_idx     <= '0;
      r_gnt     <= '0;
      r_start   <= '0;
      r_stop    <= '0;
      r_aborted <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_aborted <= w_abort_exit;
      if (r_state == IDLE && w_arb_valid) begin
        r_idx   <= w_arb_idx;
        r_gnt   <= w_arb_onehot;
        r_start <= start_val[int'(w_arb_idx)*WIDTH +: WIDTH];
        r_stop  <= stop_val[int'(w_arb_idx)*WIDTH +: WIDTH];
      end else if (w_state_nxt == IDLE) begin
        r_gnt <= '0;
      end
      if (w_job_exit) r_ptr <= w_ptr_nxt;
    end
  end

`ifdef CLS_WATCHDOG_EN
  localparam logic [WIDTH+1:0] WD_LIMIT = (WIDTH+2)'(cls_wd_limit(WIDTH));
  logic [WIDTH+1:0] r_wd;
  logic             r_timeout;

  // r_wd holds the number of RUN cycles already completed in this job.
  assign w_wd_expired = (r_state == RUN) && (r_wd == WD_LIMIT);

  // RUN-cycle counter and timeout pulse.
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      r_wd      <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_wd_expired;
      r_wd      <= (r_state == RUN) ? r_wd + (WIDTH+2)'(1) : '0;
    end
  end

  assign timeout = r_timeout;
`else
  assign w_wd_expired = 1'b0;
`endif

  assign ld_en   = (r_state == LOAD);
  assign load    = ld_en ? r_start : '0;
  assign cnt_en  = (r_state == RUN) && (cnt_in != r_stop);
  assign gnt     = r_gnt;
  assign done    = (r_state == DONE) ? r_gnt : '0;
  assign aborted = r_aborted;
  assign busy    = (r_state != IDLE);

endmodule

// File: tb/tb_counter_load_sched.sv
// Self-checking bench for counter_load_sched with a behavioural loadable counter.
// Build with CLS_WATCHDOG_EN defined to exercise the watchdog variant.
module tb_counter_load_sched;

  localparam int WIDTH = 4;
  localparam int NREQ  = 2;

  logic       clk = 1'b0;
  logic       Rst;
  logic [1:0] req;
  logic [7:0] start_val, stop_val;
  logic       abort;
  logic [3:0] cnt_in = 4'd0;
  logic       ld_en, cnt_en, aborted, busy;
  logic [3:0] load;
  logic [1:0] gnt, done;
`ifdef CLS_WATCHDOG_EN
  logic       timeout;
`endif
  logic       freeze = 1'b0;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [1:0] gnt;
    logic [3:0] load;
    int         run_len;
    int         en_cnt;
    logic [1:0] done;
    logic       ab;
    logic       to;
  } job_t;

  typedef struct {
    logic [1:0] req;
    int         idx;
    logic [3:0] start;
    logic [3:0] stop;
    logic [1:0] gnt;
  } vec_t;

  job_t exp_q[$];

  counter_load_sched #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk       (clk),
    .Rst       (Rst),
    .req       (req),
    .start_val (start_val),
    .stop_val  (stop_val),
    .abort     (abort),
    .cnt_in    (cnt_in),
    .ld_en     (ld_en),
    .load      (load),
    .cnt_en    (cnt_en),
    .gnt       (gnt),
    .done      (done),
    .aborted   (aborted),
    .busy      (busy)
`ifdef CLS_WATCHDOG_EN
    ,
    .timeout   (timeout)
`endif
  );

  always #5 clk = ~clk;

  // Loadable up-counter; freeze models a stuck counter.
  always @(posedge clk) begin
    if (ld_en) cnt_in <= load;
    else if (cnt_en && !freeze) cnt_in <= cnt_in + 4'd1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vals(input int idx, input logic [3:0] s, input logic [3:0] e);
    start_val = {~s, ~s};
    stop_val  = {~e, ~e};
    start_val[idx*4 +: 4] = s;
    stop_val[idx*4 +: 4]  = e;
  endtask

  task automatic push(input logic [1:0] g, input logic [3:0] ld, input int rl, input int en,
                      input logic [1:0] dn, input logic ab, input logic to);
    job_t x;
    x.gnt = g; x.load = ld; x.run_len = rl; x.en_cnt = en; x.done = dn; x.ab = ab; x.to = to;
    exp_q.push_back(x);
  endtask

  // Returns at the cycle where done or aborted is visible; optionally scrambles inputs mid-job.
  task automatic wait_end(input int budget, input bit scramble, input string tag);
    int n;
    n = 0;
    while (done == 2'b00 && !aborted && n < budget) begin
      tick();
      n++;
      if (scramble && n == 3) begin
        start_val = 8'($urandom);
        stop_val  = 8'($urandom);
      end
    end
    if (n >= budget) chk({tag, "_bound"}, 32'd0, 32'd1);
  endtask

  // Scoreboard monitor: accumulates each job's observed profile and compares on completion.
  initial begin : mon
    int run_n, en_n;
    logic [1:0] g;
    logic [3:0] ld;
    job_t e;
    run_n = 0; en_n = 0; g = 2'b00; ld = 4'd0;
    forever begin
      @(negedge clk);
      if (Rst) begin
        run_n = 0;
        en_n  = 0;
      end else begin
        chk("gnt_vs_busy", 32'($countones(gnt)), busy ? 32'd1 : 32'd0);
        if (ld_en) begin
          g = gnt; ld = load; run_n = 0; en_n = 0;
        end else if (busy && done == 2'b00) begin
          run_n++;
          if (cnt_en) en_n++;
        end
        if (done != 2'b00 || aborted) begin
          if (exp_q.size() == 0) begin
            chk("sb_unexpected_end", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("sb_gnt", 32'(g), 32'(e.gnt));
            chk("sb_load", 32'(ld), 32'(e.load));
            chk("sb_run_len", run_n, e.run_len);
            chk("sb_cnt_en_cycles", en_n, e.en_cnt);
            chk("sb_done", 32'(done), 32'(e.done));
            chk("sb_aborted", 32'(aborted), 32'(e.ab));
`ifdef CLS_WATCHDOG_EN
            chk("sb_timeout", 32'(timeout), 32'(e.to));
`endif
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: got expired expected finish");
    $fatal(1);
  end

  initial begin : stim
    vec_t vt[5];
    logic [3:0] d;
    int hb, n;

    vt[0] = '{req: 2'b01, idx: 0, start: 4'd14, stop: 4'd1,  gnt: 2'b01};
    vt[1] = '{req: 2'b01, idx: 0, start: 4'd5,  stop: 4'd5,  gnt: 2'b01};
    vt[2] = '{req: 2'b10, idx: 1, start: 4'd9,  stop: 4'd12, gnt: 2'b10};
    vt[3] = '{req: 2'b01, idx: 0, start: 4'd0,  stop: 4'd15, gnt: 2'b01};
    vt[4] = '{req: 2'b10, idx: 1, start: 4'd7,  stop: 4'd6,  gnt: 2'b10};

    Rst = 1'b1; req = 2'b00; abort = 1'b0; start_val = 8'd0; stop_val = 8'd0;
    tick(); tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_ld_en", 32'(ld_en), 32'd0);
    Rst = 1'b0;
    tick();

    // Basic job 3 -> 6 with cycle-exact checks.
    set_vals(0, 4'd3, 4'd6);
    req = 2'b01;
    push(2'b01, 4'd3, 4, 3, 2'b01, 1'b0, 1'b0);
    tick();
    chk("t2_gnt", 32'(gnt), 32'd1);
    chk("t2_ld_en", 32'(ld_en), 32'd1);
    chk("t2_load", 32'(load), 32'd3);
    chk("t2_cnt_en_in_load", 32'(cnt_en), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_cnt_en_run", 32'(cnt_en), 32'd1);
      chk("t2_cnt_val", 32'(cnt_in), 32'(3 + i));
    end
    tick();
    chk("t2_cnt_en_at_stop", 32'(cnt_en), 32'd0);
    tick();
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_gnt_held", 32'(gnt), 32'd1);
    req = 2'b00;
    tick();
    chk("t2_done_pulse", 32'(done), 32'd0);
    chk("t2_idle", 32'(busy), 32'd0);

    // Table-driven single jobs, incl. wrap and start==stop; inputs scrambled mid-job.
    for (int v = 0; v < 5; v++) begin
      set_vals(vt[v].idx, vt[v].start, vt[v].stop);
      req = vt[v].req;
      d = vt[v].stop - vt[v].start;
      push(vt[v].gnt, vt[v].start, int'(d) + 1, int'(d), vt[v].gnt, 1'b0, 1'b0);
      wait_end(40, 1'b1, "vec");
      req = 2'b00;
      tick(); tick();
      chk("vec_idle", 32'(busy), 32'd0);
    end

    // Fair rotation with both requests held.
    start_val = 8'h00; stop_val = 8'h22;
    push(2'b01, 4'd0, 3, 2, 2'b01, 1'b0, 1'b0);
    push(2'b10, 4'd0, 3, 2, 2'b10, 1'b0, 1'b0);
    push(2'b01, 4'd0, 3, 2, 2'b01, 1'b0, 1'b0);
    push(2'b10, 4'd0, 3, 2, 2'b10, 1'b0, 1'b0);
    req = 2'b11;
    for (int j = 0; j < 4; j++) begin
      wait_end(20, 1'b0, "rot");
      if (j == 3) req = 2'b00;
      tick();
    end
    tick();

    // Abort in the second RUN cycle.
    set_vals(0, 4'd0, 4'd10);
    req = 2'b01;
    push(2'b01, 4'd0, 2, 2, 2'b00, 1'b1, 1'b0);
    tick(); tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_aborted", 32'(aborted), 32'd1);
    chk("ab_no_done", 32'(done), 32'd0);
    chk("ab_idle", 32'(busy), 32'd0);
    chk("ab_gnt_clear", 32'(gnt), 32'd0);
    req = 2'b00;
    tick();
    chk("ab_pulse", 32'(aborted), 32'd0);

    // Abort while idle is ignored.
    abort = 1'b1;
    tick(); tick();
    chk("ab_idle_ignored", 32'(aborted), 32'd0);
    chk("ab_idle_busy", 32'(busy), 32'd0);
    abort = 1'b0;

    // Reset mid-RUN; pointer (currently 1) must return to 0.
    set_vals(1, 4'd0, 4'd15);
    req = 2'b10;
    tick(); tick(); tick(); tick();
    Rst = 1'b1;
    #1;
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_gnt", 32'(gnt), 32'd0);
    chk("mr_ld_en", 32'(ld_en), 32'd0);
    chk("mr_load", 32'(load), 32'd0);
    chk("mr_cnt_en", 32'(cnt_en), 32'd0);
    chk("mr_done", 32'(done), 32'd0);
    chk("mr_aborted", 32'(aborted), 32'd0);
    tick();
    Rst = 1'b0;
    req = 2'b11;
    start_val = {4'd9, 4'd2};
    stop_val  = {4'd9, 4'd3};
    push(2'b01, 4'd2, 2, 1, 2'b01, 1'b0, 1'b0);
    tick();
    chk("mr_first_grant", 32'(gnt), 32'd1);
    wait_end(20, 1'b0, "mr");
    req = 2'b00;
    tick(); tick();

    // Abort on the stop-match cycle; pointer is 1 so requester 1 wins.
    start_val = 8'h44; stop_val = 8'h55;
    req = 2'b11;
    push(2'b10, 4'd4, 2, 1, 2'b00, 1'b1, 1'b0);
    tick();
    chk("am_grant", 32'(gnt), 32'd2);
    tick(); tick();
    chk("am_match_cnt_en", 32'(cnt_en), 32'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    req = 2'b00;
    chk("am_aborted", 32'(aborted), 32'd1);
    chk("am_no_done", 32'(done), 32'd0);
    tick(); tick();

    // Stuck counter.
    freeze = 1'b1;
    set_vals(0, 4'd0, 4'd9);
    req = 2'b01;
`ifdef CLS_WATCHDOG_EN
    push(2'b01, 4'd0, 18, 18, 2'b00, 1'b1, 1'b1);
    n = 0;
    while (!aborted && n < 40) begin
      tick();
      n++;
    end
    chk("wd_latency", n, 20);
    chk("wd_timeout", 32'(timeout), 32'd1);
    chk("wd_idle", 32'(busy), 32'd0);
    req = 2'b00;
    tick();
    chk("wd_timeout_pulse", 32'(timeout), 32'd0);
`else
    push(2'b01, 4'd0, 31, 31, 2'b00, 1'b1, 1'b0);
    tick(); tick();
    hb = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (busy) hb++;
    end
    chk("nowd_busy_held", hb, 30);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    req = 2'b00;
    chk("nowd_abort", 32'(aborted), 32'd1);
`endif
    freeze = 1'b0;
    tick(); tick();
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
